// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file + ALU datapath.
// Holds the sequencer state encoding, the ALU operation codes and the R-type encoding constants.
// The ALU imports this package too, so the op codes are defined in one place only.
package datapath_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // RV32 R-type encoding
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational RV32 R-type decoder.
// Ports:
//   instr       in   instruction word (only 32-bit words are supported)
//   legal       out  1 when the word is a supported R-type instruction
//   alu_control out  ALU operation code (ADD when not legal; ignored by the sequencer then)
//   rs1/rs2/rd  out  register fields extracted straight from the word
module rtype_decoder
  import datapath_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               legal,
  output logic [3:0]         alu_control,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    legal       = 1'b0;
    alu_control = ALU_ADD;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          3'b000:  alu_control = ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        // Only SUB and SRA have an alternate-funct7 form
        case (funct3)
          3'b000: begin
            legal       = 1'b1;
            alu_control = ALU_SUB;
          end
          3'b101: begin
            legal       = 1'b1;
            alu_control = ALU_SRA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the register-file + ALU datapath.
// Accepts one R-type instruction at a time over valid/ready, then walks
// IDLE -> DECODE -> EXEC -> WB -> IDLE, retiring one instruction per 4 cycles (plus hold cycles).
// Illegal encodings return from DECODE to IDLE with a 1-cycle illegal pulse.
// Optional feature macro: RETIRE_CNT_EN adds the CNT_W parameter and the retire_cnt port.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-low reset
//   instr, instr_valid     instruction word and its valid; instr_ready high only in IDLE
//   hold                   stalls EXEC (no commit while high)
//   zero_flag              ALU zero flag, captured into zero_out when leaving EXEC
//   rs1, rs2, rd           register-file addresses (registered, held in IDLE)
//   alu_control            ALU op code (registered, held in IDLE)
//   regwrite, done         asserted in WB; regwrite suppressed for rd == x0
//   illegal                1-cycle pulse after a rejected instruction
//   retire_cnt             retired-instruction count (RETIRE_CNT_EN only)
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
`ifdef RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               hold,
  input  logic               zero_flag,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [3:0]         alu_control,
  output logic               regwrite,
  output logic               done,
  output logic               illegal,
  output logic               zero_out
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]   retire_cnt
`endif
);

  state_t state_q, state_d;

  logic [INSTR_W-1:0] instr_q;
  logic [4:0]         rs1_q, rs2_q, rd_q;
  logic [3:0]         alu_q;
  logic               illegal_q;
  logic               zero_q;

  logic               dec_legal;
  logic [3:0]         dec_alu;
  logic [4:0]         dec_rs1, dec_rs2, dec_rd;

  rtype_decoder #(
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .instr       (instr_q),
    .legal       (dec_legal),
    .alu_control (dec_alu),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd)
  );

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    regwrite    = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = DECODE;
      end
      DECODE: state_d = dec_legal ? EXEC : IDLE;
      EXEC: begin
        if (!hold) state_d = WB;
      end
      WB: begin
        done     = 1'b1;
        regwrite = (rd_q != 5'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == DECODE) && !dec_legal;
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      // Fields only change on a legal decode, so they stay put across illegal words and IDLE
      if (state_q == DECODE && dec_legal) begin
        rs1_q <= dec_rs1;
        rs2_q <= dec_rs2;
        rd_q  <= dec_rd;
        alu_q <= dec_alu;
      end
      if (state_q == EXEC && !hold) zero_q <= zero_flag;
    end
  end

  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign alu_control = alu_q;
  assign illegal     = illegal_q;
  assign zero_out    = zero_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed scenarios plus randomized instructions
// checked against a table-driven decode model and a cycle-count timing model.
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        hold = 1'b0;
  logic        zero_flag = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control;
  logic        regwrite, done, illegal, zero_out;
`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  datapath_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .hold        (hold),
    .zero_flag   (zero_flag),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .alu_control (alu_control),
    .regwrite    (regwrite),
    .done        (done),
    .illegal     (illegal),
    .zero_out    (zero_out)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       legal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu;
  } dec_t;

  // Reference decode straight from the instruction-set table
  function automatic dec_t model(input logic [31:0] w);
    dec_t e;
    e.rs1   = w[19:15];
    e.rs2   = w[24:20];
    e.rd    = w[11:7];
    e.legal = 1'b0;
    e.alu   = 4'b0010;
    if (w[6:0] == 7'h33 && w[31:25] == 7'h00) begin
      e.legal = 1'b1;
      case (w[14:12])
        3'd0: e.alu = 4'b0010;  // add
        3'd1: e.alu = 4'b0100;  // sll
        3'd2: e.alu = 4'b0111;  // slt
        3'd3: e.alu = 4'b1001;  // sltu
        3'd4: e.alu = 4'b0011;  // xor
        3'd5: e.alu = 4'b0101;  // srl
        3'd6: e.alu = 4'b0001;  // or
        3'd7: e.alu = 4'b0000;  // and
        default: ;
      endcase
    end else if (w[6:0] == 7'h33 && w[31:25] == 7'h20) begin
      if (w[14:12] == 3'd0) begin e.legal = 1'b1; e.alu = 4'b0110; end
      if (w[14:12] == 3'd5) begin e.legal = 1'b1; e.alu = 4'b1000; end
    end
    return e;
  endfunction

  // Fields the DUT should be showing in IDLE (last legal instruction, 0 after reset)
  logic [18:0] last_fields = '0;

  // Drives one instruction from IDLE back to IDLE and checks every cycle on the falling edge.
  task automatic run_instr(input logic [31:0] w, input int hold_n, input logic zf,
                           input logic keep_valid, input string tag);
    dec_t        e;
    logic [18:0] ef;
    e  = model(w);
    ef = {e.rs1, e.rs2, e.rd, e.alu};
    @(negedge clock);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b want 1", tag, instr_ready);
    end
    instr = w; instr_valid = 1'b1; hold = 1'b0;
    @(negedge clock);  // DECODE
    instr = $urandom();
    if (!keep_valid) instr_valid = 1'b0;
    n_cmp++;
    if ({instr_ready, illegal, done, regwrite} !== 4'b0000) begin
      n_fail++; $display("FAIL %s decode_outs: got %b want 0000", tag,
                         {instr_ready, illegal, done, regwrite});
    end
    hold = (hold_n > 0);
    zero_flag = (hold_n > 0) ? ~zf : zf;
    @(negedge clock);
    if (!e.legal) begin
      n_cmp++;
      if ({illegal, instr_ready, done, regwrite} !== 4'b1100) begin
        n_fail++; $display("FAIL %s illegal_pulse: got %b want 1100", tag,
                           {illegal, instr_ready, done, regwrite});
      end
      n_cmp++;
      if ({rs1, rs2, rd, alu_control} !== last_fields) begin
        n_fail++; $display("FAIL %s fields_kept: got %h want %h", tag,
                           {rs1, rs2, rd, alu_control}, last_fields);
      end
      instr_valid = 1'b0; hold = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({illegal, instr_ready, regwrite} !== 3'b010) begin
        n_fail++; $display("FAIL %s illegal_end: got %b want 010", tag,
                           {illegal, instr_ready, regwrite});
      end
      return;
    end
    // EXEC
    n_cmp++;
    if ({rs1, rs2, rd, alu_control} !== ef) begin
      n_fail++; $display("FAIL %s exec_fields: got %h want %h", tag,
                         {rs1, rs2, rd, alu_control}, ef);
    end
    n_cmp++;
    if ({instr_ready, done, regwrite, illegal} !== 4'b0000) begin
      n_fail++; $display("FAIL %s exec_outs: got %b want 0000", tag,
                         {instr_ready, done, regwrite, illegal});
    end
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({rs1, rs2, rd, alu_control, instr_ready, done, regwrite} !== {ef, 3'b000}) begin
        n_fail++; $display("FAIL %s hold_stable: got %h want %h", tag,
                           {rs1, rs2, rd, alu_control, instr_ready, done, regwrite},
                           {ef, 3'b000});
      end
      if (i == hold_n - 1) begin hold = 1'b0; zero_flag = zf; end
    end
    @(negedge clock);  // WB
    n_cmp++;
    if ({done, regwrite, instr_ready} !== {1'b1, e.rd != 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL %s wb_outs: got %b want %b", tag, {done, regwrite, instr_ready},
                         {1'b1, e.rd != 5'd0, 1'b0});
    end
    n_cmp++;
    if ({zero_out, rs1, rs2, rd, alu_control} !== {zf, ef}) begin
      n_fail++; $display("FAIL %s wb_zero_fields: got %h want %h", tag,
                         {zero_out, rs1, rs2, rd, alu_control}, {zf, ef});
    end
    exp_cnt++;
    last_fields = ef;
    @(negedge clock);  // back in IDLE
    instr_valid = 1'b0;
    n_cmp++;
    if ({done, regwrite, instr_ready, rs1, rs2, rd, alu_control} !== {3'b001, ef}) begin
      n_fail++; $display("FAIL %s idle_after: got %h want %h", tag,
                         {done, regwrite, instr_ready, rs1, rs2, rd, alu_control}, {3'b001, ef});
    end
`ifdef RETIRE_CNT_EN
    n_cmp++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL %s retire_cnt: got %0d want %0d", tag, retire_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({instr_ready, rs1, rs2, rd, alu_control, regwrite, done, illegal, zero_out}
        !== {1'b1, 23'd0}) begin
      n_fail++; $display("FAIL reset_outs: got %h want %h",
                         {instr_ready, rs1, rs2, rd, alu_control, regwrite, done, illegal, zero_out},
                         {1'b1, 23'd0});
    end
    reset = 1'b1;
    exp_cnt = 0;
    last_fields = '0;
  endtask

  task automatic test_add();
    run_instr(32'h002081B3, 0, 1'b0, 1'b0, "add_x3");
  endtask

  task automatic test_sub_zero();
    run_instr(32'h401082B3, 0, 1'b1, 1'b0, "sub_x5");
  endtask

  task automatic test_illegal();
    run_instr(32'h00100093, 0, 1'b0, 1'b0, "addi");
    run_instr(32'h402091B3, 0, 1'b0, 1'b0, "f7alt_sll");
  endtask

  task automatic test_x0_write();
    run_instr(32'h00208033, 0, 1'b1, 1'b0, "add_x0");
  endtask

  task automatic test_hold();
    run_instr(32'h0020F1B3, 5, 1'b1, 1'b1, "hold5_and");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    instr = 32'h00A5C233; instr_valid = 1'b1;  // xor x4,x11,x10
    @(negedge clock);
    instr_valid = 1'b0;
    hold = 1'b1;
    @(negedge clock);  // EXEC
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({instr_ready, rs1, rs2, rd, alu_control, regwrite, done, illegal, zero_out}
        !== {1'b1, 23'd0}) begin
      n_fail++; $display("FAIL reset_mid_outs: got %h want %h",
                         {instr_ready, rs1, rs2, rd, alu_control, regwrite, done, illegal, zero_out},
                         {1'b1, 23'd0});
    end
    reset = 1'b1; hold = 1'b0;
    exp_cnt = 0;
    last_fields = '0;
    @(negedge clock);
    n_cmp++;
    if ({regwrite, done, instr_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_mid_after: got %b want 001", {regwrite, done, instr_ready});
    end
`ifdef RETIRE_CNT_EN
    n_cmp++;
    if (retire_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_cnt: got %0d want 0", retire_cnt);
    end
`endif
  endtask

  task automatic test_retire_count();
    run_instr(32'h002081B3, 0, 1'b0, 1'b0, "cnt_a");
    run_instr(32'h00100093, 0, 1'b0, 1'b0, "cnt_ill");
    run_instr(32'h4020D1B3, 1, 1'b0, 1'b0, "cnt_sra");
    run_instr(32'h0020B1B3, 0, 1'b1, 1'b0, "cnt_sltu");
`ifdef RETIRE_CNT_EN
    n_cmp++;
    if (retire_cnt !== 16'd3) begin
      n_fail++; $display("FAIL retire_cnt_three: got %0d want 3", retire_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [2:0]  f3;
    for (int n = 0; n < 40; n++) begin
      w = $urandom();
      case ($urandom_range(0, 3))
        0: ;  // raw word, almost always illegal
        1: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
        default: begin
          w[6:0] = 7'h33;
          f3 = w[14:12];
          w[31:25] = ($urandom_range(0, 3) == 0 && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
        end
      endcase
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_illegal();
    test_x0_write();
    test_hold();
    test_reset_mid();
    test_retire_count();
    test_random();
    test_back_to_back: begin
      run_instr(32'h002091B3, 0, 1'b0, 1'b0, "b2b_sll");
      run_instr(32'h0020A1B3, 0, 1'b1, 1'b0, "b2b_slt");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
